diff_operator_multi: RTL and testbench
======================================

DIFF_OPERATOR_MULTI -- requirements
Module: diff_operator_multi

Interface
REQ-001 The block SHALL have parameter ROWS, default 8, giving samples per frame (>=2).
REQ-002 The block SHALL have parameter ORDER, default 1, giving difference order (>=1).
REQ-003 The block SHALL have parameter OUT_RES, default 16, giving signed sample width in bits.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 clear  in  1  synchronous history clear and abort.
REQ-007 in_valid  in  1  frame present on in.
REQ-008 in_ready  out  1  block idle, frame accepted when in_valid is high.
REQ-009 in  in  ROWS x OUT_RES signed  input frame, row 0 oldest.
REQ-010 out_valid  out  1  one-cycle pulse, out holds a new result.
REQ-011 out  out  ROWS x OUT_RES signed  differenced frame, held until the next out_valid.

Function
REQ-012 The block SHALL compute the ORDER-th backward difference across frames: stage 0 is the captured in; d_k[r] = s_(k-1)[r] - (r==0 ? hist_k : s_(k-1)[r-1]) for k = 1..ORDER; out = d_ORDER.
REQ-013 hist_k SHALL equal s_(k-1)[ROWS-1] from the previous accepted frame, or 0 after reset or clear.
REQ-014 The FSM SHALL have states IDLE, CALC, CARRY and DONE.
- IDLE -> CALC on in_valid & in_ready, capturing in.
- CALC -> CARRY after ROWS*ORDER cycles.
- CARRY -> DONE after 1 cycle.
- DONE -> IDLE after 1 cycle.
REQ-015 CALC SHALL produce one element per cycle, row-major within a stage, stages 1..ORDER in order.
REQ-016 CARRY SHALL update all hist_k from the pre-difference stage values of the current frame.
REQ-017 In DONE, out SHALL be updated and out_valid SHALL be high for exactly that cycle.
REQ-018 Latency from the accept edge to out_valid high SHALL be ROWS*ORDER+2 cycles.
REQ-019 in_ready SHALL be high only in IDLE; in_valid outside IDLE SHALL be ignored, with no queuing.
REQ-020 Subtraction SHALL be OUT_RES-bit two's-complement with modulo 2^OUT_RES wrap, making the block the exact inverse of the team's cumulative-sum operator.
REQ-021 clear in IDLE SHALL zero all hist_k.
REQ-022 clear in CALC, CARRY or DONE SHALL zero all hist_k, return the FSM to IDLE, and suppress out_valid; out SHALL keep its prior value.
REQ-023 clear coincident with in_valid in IDLE SHALL take priority, so no frame is accepted.

Reset
REQ-024 While reset_n is low, the FSM SHALL be IDLE, all hist_k, stage storage and out SHALL be 0, out_valid SHALL be 0, and in_ready SHALL be 1 after deassertion.
REQ-025 Reset asserted mid-CALC SHALL discard the frame with no out_valid.

Configuration
REQ-026 With macro DIFF_OPERATOR_SAT_EN defined, each subtraction SHALL saturate to [-2^(OUT_RES-1), 2^(OUT_RES-1)-1].
REQ-027 Without DIFF_OPERATOR_SAT_EN, subtraction SHALL wrap per REQ-020; all other behaviour and timing SHALL be identical.

Structure
REQ-028 The FSM state enum and the saturating-subtract function SHALL live in the shared operator package alongside the OUT_RES and J constants; the ROWS default SHALL be derived there as J+1 where instantiated.
REQ-029 The block SHALL use one sub-module, diff_stage_sub: a combinational OUT_RES subtractor with an optional saturation path, instantiated once and time-shared across CALC.

Verification
REQ-030 Basic first order: ROWS=4, ORDER=1, after reset send {1,3,6,10} -> out {1,2,3,4}; then send {15,21,28,36} -> out {5,6,7,8}; out_valid exactly 6 cycles after each accept.
REQ-031 Second order: ROWS=4, ORDER=2, send {1,3,6,10} -> out {1,1,1,1}; latency 10 cycles.
REQ-032 Wrap: OUT_RES=8, ORDER=1, send {-128,127,0,0} -> out {-128,-1,-127,0}; with DIFF_OPERATOR_SAT_EN defined -> out {-128,127,-127,0}.
REQ-033 Clear mid-frame: assert clear 2 cycles into CALC -> no out_valid, in_ready high the next cycle; next frame {5,5,5,5} -> out {5,0,0,0}.
REQ-034 Back-pressure and reset: in_valid held high during CALC -> only one frame accepted; reset_n low mid-CALC -> out=0, out_valid=0, in_ready=1 after release.
REQ-035 Round trip: random frames passed through the cumulative-sum operator, then this block with equal ORDER and wrap mode -> output equals the original stimulus bit-exact.

Source files
------------

// File: rtl/diff_operator_multi_pkg.sv
// diff_operator_multi_pkg: shared operator types, constants and saturating subtract.
package diff_operator_multi_pkg;
    localparam int OUT_RES = 16;
    localparam int J = 7;
    typedef enum logic [1:0] {IDLE, CALC, CARRY, DONE} state_t;
    function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        logic signed [63:0] d, hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        d = a - b;
        return d > hi ? hi : d < lo ? lo : d;
    endfunction
endpackage

// File: rtl/diff_operator_multi_sub.sv
// diff_stage_sub: OUT_RES-bit subtractor, wrapping by default or saturating with DIFF_OPERATOR_SAT_EN.
module diff_stage_sub #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] y_o
);
`ifdef DIFF_OPERATOR_SAT_EN
    import diff_operator_multi_pkg::*;
    assign y_o = W'(sat_sub(64'(a_i), 64'(b_i), W));
`else
    assign y_o = a_i - b_i;
`endif
endmodule

// File: rtl/diff_operator_multi.sv
// diff_operator_multi: ORDER-th backward difference across frames, one element per cycle.
// Optional saturation is selected by the DIFF_OPERATOR_SAT_EN macro.
module diff_operator_multi #(
    parameter int ROWS    = diff_operator_multi_pkg::J + 1,
    parameter int ORDER   = 1,
    parameter int OUT_RES = diff_operator_multi_pkg::OUT_RES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [OUT_RES-1:0] in [ROWS],
    output logic                      out_valid,
    output logic signed [OUT_RES-1:0] out [ROWS]
);
    import diff_operator_multi_pkg::*;
    localparam int RW = $clog2(ROWS);
    localparam int KW = ORDER > 1 ? $clog2(ORDER) : 1;
    state_t state_q;
    logic signed [OUT_RES-1:0] s_q [ROWS];
    logic signed [OUT_RES-1:0] out_q [ROWS];
    logic signed [OUT_RES-1:0] hist_q [ORDER];
    logic signed [OUT_RES-1:0] nh_q [ORDER];
    logic signed [OUT_RES-1:0] prev_q, a, b, d;
    logic [RW-1:0] r_q;
    logic [KW-1:0] k_q;
    logic out_valid_q, last_row, last_elem;
    // prev_q keeps the pre-difference value of the row just overwritten in place
    assign a = s_q[r_q];
    assign b = r_q == '0 ? hist_q[k_q] : prev_q;
    assign last_row = r_q == RW'(ROWS - 1);
    assign last_elem = last_row && k_q == KW'(ORDER - 1);
    assign in_ready = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign out = out_q;
    diff_stage_sub #(.W(OUT_RES)) u_sub (.a_i(a), .b_i(b), .y_o(d));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            r_q <= '0;
            k_q <= '0;
            prev_q <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                s_q[i] <= '0;
                out_q[i] <= '0;
            end
            for (int i = 0; i < ORDER; i++) begin
                hist_q[i] <= '0;
                nh_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (clear) begin
                state_q <= IDLE;
                for (int i = 0; i < ORDER; i++) hist_q[i] <= '0;
            end else begin
                case (state_q)
                    IDLE: if (in_valid) begin
                        s_q <= in;
                        r_q <= '0;
                        k_q <= '0;
                        state_q <= CALC;
                    end
                    CALC: begin
                        s_q[r_q] <= d;
                        prev_q <= a;
                        if (last_row) nh_q[k_q] <= a;
                        r_q <= last_row ? '0 : r_q + 1'b1;
                        k_q <= last_row ? k_q + 1'b1 : k_q;
                        if (last_elem) state_q <= CARRY;
                    end
                    CARRY: begin
                        hist_q <= nh_q;
                        state_q <= DONE;
                    end
                    default: begin
                        out_q <= s_q;
                        out_valid_q <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_diff_operator_multi.sv
// tb_diff_operator_multi: scoreboard bench for first- and second-order instances at 8-bit width.
module tb_diff_operator_multi;
    typedef logic [3:0][7:0] frame_t;
    typedef struct {frame_t f; int due;} sb_t;
    logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, in_valid = 1'b0;
    logic rdy1, rdy2, ov1, ov2;
    logic signed [7:0] din1 [4], din2 [4], out1 [4], out2 [4];
    frame_t o1p, o2p;
    logic [1:0][7:0] h1 = '0, h2 = '0, a1 = '0, a2 = '0;
    sb_t q1 [$], q2 [$];
    sb_t e_1, e_2;
    int tests = 0, fails = 0, cyc = 0, n_ov1 = 0, n_ov2 = 0;
    diff_operator_multi #(.ROWS(4), .ORDER(1), .OUT_RES(8)) u1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy1),
        .in(din1), .out_valid(ov1), .out(out1));
    diff_operator_multi #(.ROWS(4), .ORDER(2), .OUT_RES(8)) u2 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
        .in(din2), .out_valid(ov2), .out(out2));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb for (int r = 0; r < 4; r++) begin
        o1p[r] = out1[r];
        o2p[r] = out2[r];
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] sub8(input logic signed [7:0] x, input logic signed [7:0] y);
`ifdef DIFF_OPERATOR_SAT_EN
        int t;
        t = int'(x) - int'(y);
        return t > 127 ? 8'sd127 : t < -128 ? -8'sd128 : 8'(t);
`else
        return x - y;
`endif
    endfunction
    task automatic diff_model(input frame_t f, input int ord, inout logic [1:0][7:0] h, output frame_t o);
        frame_t p;
        o = f;
        for (int k = 0; k < ord; k++) begin
            p = o;
            for (int r = 0; r < 4; r++) o[r] = sub8(p[r], r == 0 ? h[k] : p[r-1]);
            h[k] = p[3];
        end
    endtask
    task automatic cumsum(input frame_t x, input int ord, inout logic [1:0][7:0] acc, output frame_t c);
        c = x;
        for (int k = 0; k < ord; k++) begin
            for (int r = 0; r < 4; r++) c[r] = (r == 0 ? acc[k] : c[r-1]) + c[r];
            acc[k] = c[3];
        end
    endtask
    task automatic drive(input frame_t f1, input frame_t f2, input frame_t e1, input frame_t e2, input bit push, input int hold);
        int n = 0;
        while (!(rdy1 && rdy2) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 100) check("ready_timeout", {30'd0, rdy1, rdy2}, 32'd3);
        for (int r = 0; r < 4; r++) begin
            din1[r] = f1[r];
            din2[r] = f2[r];
        end
        in_valid = 1'b1;
        if (push) begin
            q1.push_back('{f: e1, due: cyc + 1 + 6});
            q2.push_back('{f: e2, due: cyc + 1 + 10});
        end
        @(posedge clk);
        repeat (hold) @(posedge clk);
        #1 in_valid = 1'b0;
    endtask
    task automatic send(input frame_t f);
        frame_t e1, e2;
        diff_model(f, 1, h1, e1);
        diff_model(f, 2, h2, e2);
        drive(f, f, e1, e2, 1'b1, 0);
    endtask
    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 200) check("drain_timeout", q1.size() + q2.size(), 0);
    endtask
    task automatic clr();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        h1 = '0;
        h2 = '0;
    endtask
    always @(negedge clk) begin
        if (ov1) begin
            n_ov1++;
            if (q1.size() == 0) check("u1_spurious", 1, 0);
            else begin
                e_1 = q1.pop_front();
                check("u1_out", o1p, e_1.f);
                check("u1_lat", cyc, e_1.due);
            end
        end
        if (ov2) begin
            n_ov2++;
            if (q2.size() == 0) check("u2_spurious", 1, 0);
            else begin
                e_2 = q2.pop_front();
                check("u2_out", o2p, e_2.f);
                check("u2_lat", cyc, e_2.due);
            end
        end
    end
    initial begin
        frame_t x, c1, c2, z;
        int base1, base2;
        z = '0;
        for (int r = 0; r < 4; r++) begin
            din1[r] = '0;
            din2[r] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_out1", o1p, 0);
        check("rst_out2", o2p, 0);
        check("rst_ov", {30'd0, ov1, ov2}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {30'd0, rdy1, rdy2}, 32'd3);
        @(posedge clk);
        #1;
        send({8'd10, 8'd6, 8'd3, 8'd1});
        drain();
        send({8'd36, 8'd28, 8'd21, 8'd15});
        drain();
        clr();
        send({8'd0, 8'd0, 8'd127, 8'h80});
        drain();
        drive({8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, z, z, 1'b0, 0);
        base1 = n_ov1;
        base2 = n_ov2;
        @(posedge clk);
        #1 check("busy_ready", {30'd0, rdy1, rdy2}, 0);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        h1 = '0;
        h2 = '0;
        check("clr_ready", {30'd0, rdy1, rdy2}, 32'd3);
        repeat (12) @(posedge clk);
        #1 check("clr_no_ov", (n_ov1 - base1) + (n_ov2 - base2), 0);
        send({8'd5, 8'd5, 8'd5, 8'd5});
        drain();
        base1 = n_ov1;
        base2 = n_ov2;
        x = {8'd9, 8'd250, 8'd17, 8'd33};
        diff_model(x, 1, h1, c1);
        diff_model(x, 2, h2, c2);
        drive(x, x, c1, c2, 1'b1, 4);
        repeat (16) @(posedge clk);
        #1 check("bp_one1", n_ov1 - base1, 1);
        check("bp_one2", n_ov2 - base2, 1);
        check("bp_drained", q1.size() + q2.size(), 0);
        base1 = n_ov1;
        base2 = n_ov2;
        drive({8'd1, 8'd2, 8'd3, 8'd4}, {8'd1, 8'd2, 8'd3, 8'd4}, z, z, 1'b0, 2);
        reset_n = 1'b0;
        h1 = '0;
        h2 = '0;
        @(negedge clk);
        check("rmid_out1", o1p, 0);
        check("rmid_out2", o2p, 0);
        check("rmid_ov", {30'd0, ov1, ov2}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rmid_ready", {30'd0, rdy1, rdy2}, 32'd3);
        repeat (12) @(posedge clk);
        #1 check("rmid_no_ov", (n_ov1 - base1) + (n_ov2 - base2), 0);
`ifndef DIFF_OPERATOR_SAT_EN
        clr();
        a1 = '0;
        a2 = '0;
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            cumsum(x, 1, a1, c1);
            cumsum(x, 2, a2, c2);
            drive(c1, c2, x, x, 1'b1, 0);
            drain();
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
